// File: rtl/preg_freelist_if.sv
// Rename/retire <-> physical register free list bundle.
// master: rename+retire side; slave: the free list.
interface preg_freelist_if #(
  parameter int TW = 6,
  parameter int CW = 7
);
  logic [2:0]    i_alloc_req;
  logic          o_alloc_grant;
  logic [TW-1:0] o_alloc_p0;
  logic [TW-1:0] o_alloc_p1;
  logic [TW-1:0] o_alloc_p2;
  logic [TW-1:0] o_alloc_p3;
  logic [2:0]    i_free_count;
  logic [TW-1:0] i_free_p0;
  logic [TW-1:0] i_free_p1;
  logic [TW-1:0] i_free_p2;
  logic [TW-1:0] i_free_p3;
  logic [CW-1:0] o_free_cnt;
  logic          o_err;

  modport master (
    output i_alloc_req, i_free_count,
    output i_free_p0, i_free_p1,
    output i_free_p2, i_free_p3,
    input  o_alloc_grant,
    input  o_alloc_p0, o_alloc_p1,
    input  o_alloc_p2, o_alloc_p3,
    input  o_free_cnt, o_err
  );

  modport slave (
    input  i_alloc_req, i_free_count,
    input  i_free_p0, i_free_p1,
    input  i_free_p2, i_free_p3,
    output o_alloc_grant,
    output o_alloc_p0, o_alloc_p1,
    output o_alloc_p2, o_alloc_p3,
    output o_free_cnt, o_err
  );
endinterface

// File: rtl/preg_freelist.sv
// Physical register free list: 4-wide alloc, 4-wide free, circular buffer.
// Ports: i_clk, i_rst_n (async low), fl (preg_freelist_if.slave).
// NPREG must be a power of two (pointers wrap by width).
// `define FREELIST_CHECK_EN adds an in-list bitmap for double-free detection.
module preg_freelist #(
  parameter int NPREG = 64,
  parameter int NARCH = 32
) (
  input logic           i_clk,
  input logic           i_rst_n,
  preg_freelist_if.slave fl
);
  localparam int TW = $clog2(NPREG);
  localparam int CW = $clog2(NPREG + 1);

  typedef logic [TW-1:0] tag_t;

  tag_t          mem [NPREG];
  tag_t          head;
  tag_t          tail;
  logic [CW-1:0] cnt;
  logic          err;

  logic [2:0]    areq;
  logic [2:0]    fcnt;
  logic [2:0]    pop;
  logic [2:0]    push;
  logic          grant;
  logic          ovf;
  logic          dbl;
  logic [CW:0]   room;
  tag_t          fp [4];

  assign fp[0] = fl.i_free_p0;
  assign fp[1] = fl.i_free_p1;
  assign fp[2] = fl.i_free_p2;
  assign fp[3] = fl.i_free_p3;

  assign areq = (fl.i_alloc_req > 3'd4) ? 3'd4 : fl.i_alloc_req;
  assign fcnt = (fl.i_free_count > 3'd4) ? 3'd4 : fl.i_free_count;

  // Frees are never bypassed: grant sees only the registered count.
  assign grant = CW'(areq) <= cnt;
  assign pop   = grant ? areq : 3'd0;

  // Slots vacated by this cycle's pops may be refilled this cycle.
  assign room = (CW+1)'(NPREG) - {1'b0, cnt} + (CW+1)'(pop);
  assign push = (room < (CW+1)'(fcnt)) ? room[2:0] : fcnt;
  assign ovf  = push != fcnt;

  assign fl.o_alloc_grant = grant;
  assign fl.o_alloc_p0    = mem[head];
  assign fl.o_alloc_p1    = mem[head + tag_t'(1)];
  assign fl.o_alloc_p2    = mem[head + tag_t'(2)];
  assign fl.o_alloc_p3    = mem[head + tag_t'(3)];
  assign fl.o_free_cnt    = cnt;
  assign fl.o_err         = err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head <= '0;
      tail <= tag_t'(NARCH);
      cnt  <= CW'(NPREG - NARCH);
      err  <= 1'b0;
      for (int i = 0; i < NPREG; i++) begin
        mem[i] <= (i < NPREG - NARCH) ? tag_t'(NARCH + i) : '0;
      end
    end else begin
      head <= head + tag_t'(pop);
      tail <= tail + tag_t'(push);
      cnt  <= cnt - CW'(pop) + CW'(push);
      err  <= err | ovf | dbl;
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < push) begin
          mem[tail + tag_t'(k)] <= fp[k];
        end
      end
    end
  end

`ifdef FREELIST_CHECK_EN
  localparam logic [NPREG-1:0] INL_RST = {NPREG{1'b1}} << NARCH;

  logic [NPREG-1:0] inl;
  logic [NPREG-1:0] inl_n;

  // Pops clear before pushes set, so a tag recycled in one cycle ends marked.
  // Every valid lane is checked, including lanes dropped on overflow.
  always_comb begin
    inl_n = inl;
    dbl   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < pop) begin
        inl_n[mem[head + tag_t'(k)]] = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < fcnt) begin
        if (inl[fp[k]]) dbl = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (fp[j] == fp[k]) dbl = 1'b1;
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < push) begin
        inl_n[fp[k]] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) inl <= INL_RST;
    else          inl <= inl_n;
  end
`else
  assign dbl = 1'b0;
`endif

endmodule

// File: tb/tb_preg_freelist.sv
// Directed bench for preg_freelist.
// Drives one interface instance; checks via immediate assertions.
module tb_preg_freelist;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   q[$];
  int   prev [4];
  int   popd [4];

  preg_freelist_if fl ();

  preg_freelist dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .fl     (fl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int req, input int fc,
                       input int a, input int b,
                       input int c, input int d);
    fl.i_alloc_req  = 3'(req);
    fl.i_free_count = 3'(fc);
    fl.i_free_p0    = 6'(a);
    fl.i_free_p1    = 6'(b);
    fl.i_free_p2    = 6'(c);
    fl.i_free_p3    = 6'(d);
    #1;
  endtask

  task automatic chk_lanes(input string tag,
                           input int e0, input int e1,
                           input int e2, input int e3);
    chk({tag, "_p0"}, 32'(fl.o_alloc_p0), e0);
    chk({tag, "_p1"}, 32'(fl.o_alloc_p1), e1);
    chk({tag, "_p2"}, 32'(fl.o_alloc_p2), e2);
    chk({tag, "_p3"}, 32'(fl.o_alloc_p3), e3);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("rst_cnt", 32'(fl.o_free_cnt), 32);
    chk("rst_err", 32'(fl.o_err), 0);
    chk("rst_grant0", 32'(fl.o_alloc_grant), 1);
    chk_lanes("rst", 32, 33, 34, 35);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_cnt", 32'(fl.o_free_cnt), 32);

    // first allocation of four
    drive(4, 0, 0, 0, 0, 0);
    chk("a4_grant", 32'(fl.o_alloc_grant), 1);
    chk_lanes("a4", 32, 33, 34, 35);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("a4_cnt", 32'(fl.o_free_cnt), 28);
    chk("a4_p0", 32'(fl.o_alloc_p0), 36);

    // drain the remaining 28
    for (int i = 0; i < 7; i++) begin
      drive(4, 0, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("drain_cnt", 32'(fl.o_free_cnt), 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("empty_grant1", 32'(fl.o_alloc_grant), 0);
    step();
    chk("empty_cnt", 32'(fl.o_free_cnt), 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("empty_grant0", 32'(fl.o_alloc_grant), 1);
    step();
    chk("hold_cnt", 32'(fl.o_free_cnt), 0);

    // frees are not bypassed to a same-cycle alloc
    drive(1, 3, 5, 6, 7, 0);
    chk("nobyp_grant", 32'(fl.o_alloc_grant), 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("nobyp_cnt", 32'(fl.o_free_cnt), 3);
    chk("nobyp_p0", 32'(fl.o_alloc_p0), 5);
    chk("nobyp_p1", 32'(fl.o_alloc_p1), 6);
    chk("nobyp_p2", 32'(fl.o_alloc_p2), 7);
    chk("nobyp_err", 32'(fl.o_err), 0);

    // refill to 32 with tags 8..36
    q = {5, 6, 7};
    for (int i = 0; i < 7; i++) begin
      drive(0, 4, 8 + 4*i, 9 + 4*i, 10 + 4*i, 11 + 4*i);
      for (int k = 0; k < 4; k++) q.push_back(8 + 4*i + k);
      step();
    end
    drive(0, 1, 36, 0, 0, 0);
    q.push_back(36);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("fill_cnt", 32'(fl.o_free_cnt), 32);

    // steady alloc4/free4; frees recycle last cycle's tags
    prev = '{0, 1, 2, 3};
    for (int c = 0; c < 16; c++) begin
      drive(4, 4, prev[0], prev[1], prev[2], prev[3]);
      chk_lanes($sformatf("wrap%0d", c),
                q[0], q[1], q[2], q[3]);
      for (int k = 0; k < 4; k++) popd[k] = q.pop_front();
      for (int k = 0; k < 4; k++) q.push_back(prev[k]);
      step();
      chk($sformatf("wrap%0d_cnt", c),
          32'(fl.o_free_cnt), 32);
      prev = popd;
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("wrap_err", 32'(fl.o_err), 0);

    // overflow: reach 62, then free 4
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(0, 4, 4*i, 4*i + 1, 4*i + 2, 4*i + 3);
      step();
    end
    drive(0, 2, 28, 29, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("ovf_pre_cnt", 32'(fl.o_free_cnt), 62);
    chk("ovf_pre_err", 32'(fl.o_err), 0);
    drive(0, 4, 30, 31, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("ovf_cnt", 32'(fl.o_free_cnt), 64);
    chk("ovf_err", 32'(fl.o_err), 1);
    chk("ovf_full_grant", 32'(fl.o_alloc_grant), 1);

    // drain and confirm lanes 2,3 were dropped
    q.delete();
    for (int t = 32; t < 64; t++) q.push_back(t);
    for (int t = 0; t < 32; t++) q.push_back(t);
    for (int c = 0; c < 16; c++) begin
      drive(4, 0, 0, 0, 0, 0);
      chk_lanes($sformatf("ovfd%0d", c),
                q[0], q[1], q[2], q[3]);
      for (int k = 0; k < 4; k++) void'(q.pop_front());
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("ovfd_cnt", 32'(fl.o_free_cnt), 0);

    // reset asserted between edges with a free in flight
    drive(4, 2, 0, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(fl.o_free_cnt), 32);
    chk("mid_rst_err", 32'(fl.o_err), 0);
    chk_lanes("mid_rst", 32, 33, 34, 35);
    step();
    chk("mid_rst_hold", 32'(fl.o_free_cnt), 32);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();

    // free a tag that is still in the list
    drive(0, 1, 40, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("dbl_cnt", 32'(fl.o_free_cnt), 33);
`ifdef FREELIST_CHECK_EN
    chk("dbl_err", 32'(fl.o_err), 1);
`else
    chk("dbl_err", 32'(fl.o_err), 0);
`endif

    // request of 7 behaves as 4
    drive(7, 0, 0, 0, 0, 0);
    chk("req7_grant", 32'(fl.o_alloc_grant), 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("req7_cnt", 32'(fl.o_free_cnt), 29);
    chk("req7_p0", 32'(fl.o_alloc_p0), 36);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/preg_freelist.md
PREG_FREELIST -- requirements
Module: preg_freelist

Interface
REQ-001 SHALL have parameter NPREG, default 64: number of physical registers; tag width 6 bits; list capacity NPREG entries.
REQ-002 SHALL have parameter NARCH, default 32: pregs 0..NARCH-1 are architecturally mapped at reset and are not initially free.
REQ-003 SHALL have port i_clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_alloc_req, input, 3: number of pregs the rename stage requests this cycle, 0..4; values 5..7 are treated as 4.
REQ-006 SHALL have port o_alloc_grant, output, 1: combinational; 1 when i_alloc_req <= o_free_cnt.
REQ-007 SHALL have ports o_alloc_p0..o_alloc_p3, output, 6 each: free-list entries at head+0..head+3 (mod NPREG); valid only for lanes below the request.
REQ-008 SHALL have port i_free_count, input, 3: number of old pregs released by retirement this cycle, 0..4; values 5..7 are treated as 4.
REQ-009 SHALL have ports i_free_p0..i_free_p3, input, 6 each: released preg tags; lane k is valid when k < i_free_count.
REQ-010 SHALL have port o_free_cnt, output, 7: registered occupancy, 0..NPREG.
REQ-011 SHALL have port o_err, output, 1: sticky error flag, registered.

Function
REQ-012 SHALL store tags in a circular buffer with 6-bit head and tail pointers that wrap modulo NPREG.
REQ-013 SHALL pop i_alloc_req entries on a rising edge only when o_alloc_grant=1; allocation is all-or-nothing, and nothing is popped when the grant is 0.
REQ-014 SHALL write lanes 0..i_free_count-1, in lane order, at tail..tail+i_free_count-1 and advance tail by i_free_count.
REQ-015 SHALL evaluate o_alloc_grant against pre-edge o_free_cnt; same-cycle frees are not bypassed to allocation and become allocatable one cycle later.
REQ-016 SHALL update o_free_cnt to o_free_cnt - popped + pushed when alloc and free occur in the same cycle.
REQ-017 SHALL never exceed NPREG: free lanes that would overflow are dropped, tail advances only by accepted lanes, and o_err is set.
REQ-018 SHALL give o_alloc_grant=1 for i_alloc_req=0 irrespective of occupancy, including when o_free_cnt=0.
REQ-019 SHALL hold all state when i_alloc_req=0 and i_free_count=0.

Reset
REQ-020 SHALL, while i_rst_n=0, force head=0, tail=NARCH, entry[i]=NARCH+i for i<NPREG-NARCH, o_free_cnt=NPREG-NARCH (32), and o_err=0.
REQ-021 SHALL present o_alloc_p0..p3 = 32, 33, 34, 35 out of reset.
REQ-022 SHALL abandon any in-flight alloc or free when reset asserts mid-operation; the list returns to the REQ-020 contents.

Configuration
REQ-023 SHALL, with FREELIST_CHECK_EN defined, keep a NPREG-bit in-list bitmap: set on push, cleared on pop, reset to ones for pregs NARCH..NPREG-1.
REQ-024 SHALL, with FREELIST_CHECK_EN defined, set o_err when a freed tag is already marked in-list or duplicated within one cycle's lanes (double-free); the push still proceeds.
REQ-025 SHALL, with FREELIST_CHECK_EN undefined, omit the bitmap, with o_err reporting overflow (REQ-017) only.

Verification
REQ-026 SHALL cover reset then i_alloc_req=4 for one cycle: grant=1, p0..p3=32..35, next cycle o_free_cnt=28 and p0=36.
REQ-027 SHALL cover a drain test: eight cycles of alloc 4 -> o_free_cnt=0; then alloc 1 -> grant=0, count stays 0; alloc 0 -> grant=1.
REQ-028 SHALL cover, from count=0, free_count=3 with tags 5,6,7 and same-cycle alloc 1: grant=0; next cycle count=3 and p0..p2=5,6,7.
REQ-029 SHALL cover wrap-around: 16 cycles of simultaneous alloc 4 / free 4 -> count constant at 32, pointers wrap past 63 with correct tag order.
REQ-030 SHALL cover overflow: at count=62, free 4 -> count=64, o_err=1, two lanes dropped; reset mid-stream -> count=32, o_err=0.
REQ-031 SHALL cover, with FREELIST_CHECK_EN, freeing tag 40 while it is still in the list -> o_err=1 next cycle; without the macro -> o_err=0.
